// File: rtl/craft_pkg.sv
// Shared CRAFT constants: S-box, nibble permutation, round-tail FSM states and
// the nibble positions that receive the round constant.
package craft_pkg;

    localparam int NIBBLES = 16;

    localparam logic [3:0] LAST_IDX  = 4'd15;
    localparam logic [3:0] RC_HI_IDX = 4'd4;
    localparam logic [3:0] RC_LO_IDX = 4'd5;

    localparam logic [3:0] PERM [NIBBLES] = '{
        4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
        4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
    };

    localparam logic [3:0] SBOX [NIBBLES] = '{
        4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/craft_sbox.sv
// Combinational 4-bit CRAFT S-box lookup.
module craft_sbox
    import craft_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);

    always_comb begin
        y = SBOX[x];
    end

endmodule

// File: rtl/craft_round_tail.sv
// Nibble-serial CRAFT round tail: constant/tweakey addition into a 16-nibble
// buffer, then replay through PermuteNibbles and the S-box (or bypass in R31).
module craft_round_tail #(
    parameter int NIBBLES = craft_pkg::NIBBLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_nibble,
    input  logic [3:0] key_nibble,
    input  logic [7:0] rc,
    input  logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_nibble,
    output logic       out_last
);

    import craft_pkg::*;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] buf_q [NIBBLES];
    logic [3:0] buf_d [NIBBLES];
    logic [7:0] rc_q, rc_d;
    logic       last_q, last_d;
    logic [3:0] out_nibble_q, out_nibble_d;
    logic       out_last_q, out_last_d;

    logic       in_fire;
    logic       out_fire;
    logic [3:0] rc_nib;
    logic [3:0] drain_idx;
    logic [3:0] sbox_in;
    logic [3:0] sbox_out;
    logic [3:0] tail_nibble;

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == DRAIN);
    assign out_nibble = out_nibble_q;
    assign out_last   = out_last_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // rc_q is already captured by the time indices 4 and 5 arrive.
    always_comb begin
        rc_nib = 4'd0;
        if (idx_q == RC_HI_IDX) begin
            rc_nib = rc_q[7:4];
        end else if (idx_q == RC_LO_IDX) begin
            rc_nib = rc_q[3:0];
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        buf_d  = buf_q;
        rc_d   = rc_q;
        last_d = last_q;
        if (in_fire) begin
            buf_d[idx_q] = in_nibble ^ key_nibble ^ rc_nib;
            if (idx_q == 4'd0) begin
                rc_d   = rc;
                last_d = last_round;
            end
        end
    end

    // Next nibble to present: index 0 when leaving FILL, idx+1 while draining.
    // Reading buf_d forwards the index-15 write made on the same edge.
    always_comb begin
        drain_idx   = (state_q == FILL) ? 4'd0 : idx_q + 4'd1;
        sbox_in     = buf_d[PERM[drain_idx]];
        tail_nibble = last_q ? buf_d[drain_idx] : sbox_out;
    end

    craft_sbox u_sbox (
        .x (sbox_in),
        .y (sbox_out)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        out_nibble_d = out_nibble_q;
        out_last_d   = out_last_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d      = DRAIN;
                        out_nibble_d = tail_nibble;
                        out_last_d   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d      = FILL;
                        out_nibble_d = 4'd0;
                        out_last_d   = 1'b0;
                    end else begin
                        out_nibble_d = tail_nibble;
                        out_last_d   = (drain_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= 4'd0;
            rc_q         <= 8'd0;
            last_q       <= 1'b0;
            out_nibble_q <= 4'd0;
            out_last_q   <= 1'b0;
            // NOTE: the buffer is reset on purpose so a discarded partial round
            // cannot leak into the next one; this keeps it in flops, not RAM.
            for (int i = 0; i < NIBBLES; i++) begin
                buf_q[i] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rc_q         <= rc_d;
            last_q       <= last_d;
            out_nibble_q <= out_nibble_d;
            out_last_q   <= out_last_d;
            buf_q        <= buf_d;
        end
    end

endmodule

// File: tb/tb_craft_round_tail.sv
// Directed bench for craft_round_tail: hand-computed round outputs, backpressure,
// input gaps, mid-round pin changes and mid-operation resets.
module tb_craft_round_tail;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_nibble;
    logic [3:0] key_nibble;
    logic [7:0] rc;
    logic       last_round;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_last;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] EXP_SBOX  = 64'hCCCCCCCCCAACCCCC;
    localparam logic [63:0] EXP_FINAL = 64'h0000110000000000;
    localparam logic [63:0] IDX_NIBS  = 64'h0123456789ABCDEF;
    localparam logic [63:0] EXP_PERM  = 64'h60241985FBE7AD3C;

    always #5 clk = ~clk;

    craft_round_tail dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_nibble  (in_nibble),
        .key_nibble (key_nibble),
        .rc         (rc),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_last   (out_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Sends the first n nibbles; alt flips rc/last_round after index 0.
    task automatic send_round(input logic [63:0] nibs, input logic [63:0] keys,
                              input logic [7:0] rc_v, input logic last_v,
                              input int n, input bit gaps, input bit alt);
        int not_ready = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    @(posedge clk);
                end
            end
            @(negedge clk);
            if (!in_ready) not_ready++;
            in_valid   = 1'b1;
            in_nibble  = nibs[63 - 4*i -: 4];
            key_nibble = keys[63 - 4*i -: 4];
            if (alt && i > 0) begin
                rc         = ~rc_v;
                last_round = ~last_v;
            end else begin
                rc         = rc_v;
                last_round = last_v;
            end
            @(posedge clk);
        end
        check("fill_in_ready", 64'(not_ready), 64'd0);
    endtask

    // Collects n output nibbles, stalling 3 cycles at index stall_at.
    task automatic recv_round(input int n, input int stall_at, input bit chk_lat,
                              output logic [63:0] data);
        int          i = 0;
        int          cycles = 0;
        int          stall_cnt = 0;
        int          busy_ready = 0;
        int          unstable = 0;
        logic [15:0] lastv = '0;
        logic [3:0]  held = '0;
        data = '0;
        while (i < n && cycles < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            cycles++;
            if (chk_lat && cycles == 1) check("latency_out_valid", 64'(out_valid), 64'd1);
            if (out_valid && in_ready) busy_ready++;
            if (i == stall_at) begin
                if (stall_cnt == 0) held = out_nibble;
                else if (out_nibble !== held || !out_valid) unstable++;
            end
            if (i == stall_at && stall_cnt < 3) begin
                stall_cnt++;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                data[63 - 4*i -: 4] = out_nibble;
                lastv[15 - i]       = out_last;
                i++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        if (i < n) check("drain_timeout", 64'(i), 64'(n));
        check("drain_in_ready_low", 64'(busy_ready), 64'd0);
        if (stall_at < n) check("stall_stable", 64'(unstable), 64'd0);
        if (n == 16) check("out_last_pattern", 64'(lastv), 64'h0001);
    endtask

    task automatic pulse_reset_and_check(input string tag);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_in_ready"},   64'(in_ready),   64'd1);
        check({tag, "_out_valid"},  64'(out_valid),  64'd0);
        check({tag, "_out_nibble"}, 64'(out_nibble), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_nibble  = '0;
        key_nibble = '0;
        rc         = '0;
        last_round = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready",   64'(in_ready),   64'd1);
        check("reset_out_valid",  64'(out_valid),  64'd0);
        check("reset_out_nibble", 64'(out_nibble), 64'd0);
        check("reset_out_last",   64'(out_last),   64'd0);

        send_round('0, '0, 8'h11, 1'b0, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b1, d);
        check("sbox_path", d, EXP_SBOX);
        check("after_drain_in_ready",  64'(in_ready),  64'd1);
        check("after_drain_out_valid", 64'(out_valid), 64'd0);

        send_round('0, '0, 8'h11, 1'b1, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b1, d);
        check("final_round_path", d, EXP_FINAL);

        send_round(IDX_NIBS, '0, 8'h00, 1'b0, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b0, d);
        check("perm_order", d, EXP_PERM);

        send_round(IDX_NIBS, '0, 8'h00, 1'b1, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b0, d);
        check("perm_bypass", d, IDX_NIBS);

        send_round('0, IDX_NIBS, 8'h00, 1'b1, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b0, d);
        check("key_xor", d, IDX_NIBS);

        send_round(IDX_NIBS, '0, 8'hA5, 1'b1, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b0, d);
        check("rc_xor", d, 64'h0123E06789ABCDEF);

        send_round('0, '0, 8'h11, 1'b0, 16, 1'b1, 1'b1);
        recv_round(16, 7, 1'b0, d);
        check("stall_sbox_path", d, EXP_SBOX);

        send_round(IDX_NIBS, '0, 8'h00, 1'b0, 16, 1'b1, 1'b1);
        recv_round(16, 7, 1'b0, d);
        check("stall_perm_order", d, EXP_PERM);

        send_round(IDX_NIBS, '0, 8'h5A, 1'b0, 9, 1'b0, 1'b0);
        @(negedge clk);
        pulse_reset_and_check("rst_mid_fill");
        send_round('0, '0, 8'h11, 1'b0, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b1, d);
        check("after_fill_reset", d, EXP_SBOX);

        send_round(IDX_NIBS, '0, 8'h00, 1'b0, 16, 1'b0, 1'b0);
        recv_round(5, 99, 1'b0, d);
        check("partial_drain", d[63:44], EXP_PERM[63:44]);
        pulse_reset_and_check("rst_mid_drain");
        send_round('0, '0, 8'h11, 1'b0, 16, 1'b0, 1'b0);
        recv_round(16, 99, 1'b1, d);
        check("after_drain_reset", d, EXP_SBOX);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/craft_round_tail.md
# craft_round_tail

Nibble-serial back half of one CRAFT round, directly downstream of `craft_mix_columns` and fed in parallel by `craft_key_register`. It consumes the 16 MixColumn output nibbles and XORs in the round constant and tweakey nibble, then buffers the state. It replays the nibbles through PermuteNibbles and the S-box, or unpermuted with no S-box in the final round, as the next round's input stream. It replaces the combinational datapath glue between the two existing stages with a valid/ready streaming buffer.

## Interface
- `NIBBLES`, default 16: state nibbles per round. Fixed for CRAFT; not user-overridable in practice.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: `in_nibble`/`key_nibble` carry a valid nibble.
- `in_ready` output 1: block can accept a nibble.
- `in_nibble` input 4: MixColumn output nibble, state index 0 first; index 0 = bits 63:60.
- `key_nibble` input 4: tweakey nibble for the same index, from `craft_key_register.out`.
- `rc` input 8: round constant. `rc[7:4]` is XORed into index 4 and `rc[3:0]` into index 5.
- `last_round` input 1: the round is R31, so skip Permute and S-box.
- `out_valid` output 1: `out_nibble` valid.
- `out_ready` input 1: downstream accepts.
- `out_nibble` output 4: next-round nibble, index 0 first.
- `out_last` output 1: high with output index 15.

## Operation
- Two states: FILL and DRAIN. 4-bit `idx` counter; 16×4 state buffer `buf`.
- **FILL**
  - `in_ready`=1 and `out_valid`=0.
  - On accept (`in_valid && in_ready`): `buf[idx] <= in_nibble ^ key_nibble ^ c(idx)`.
    - c(4) = `rc[7:4]`, c(5) = `rc[3:0]`, else c = 0.
  - `rc` and `last_round` are sampled on the accept of idx 0 and held for the rest of the round. Later values on those pins are ignored.
  - `idx` increments on each accept. On the accept at idx 15, `idx` wraps to 0 and the state goes to DRAIN.
  - If `in_valid`=0, the block waits indefinitely with no state change.
- **DRAIN**
  - `in_ready`=0 and `out_valid`=1.
  - `out_nibble` = SBOX[buf[PERM[idx]]], or buf[idx] when the held `last_round`=1. The output is registered.
  - `out_last` = (idx==15).
  - On accept (`out_valid && out_ready`): `idx` increments. The accept at idx 15 wraps `idx` to 0 and returns to FILL.
  - With `out_ready`=0, `out_nibble`, `out_last` and `idx` are held stable. The hold lasts any number of cycles.
- PERM = [15,12,13,14,10,9,8,11,6,5,4,7,1,2,3,0].
- SBOX = [C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6].
- All XORs are 4-bit with no carry. `idx` arithmetic is mod 16.
- Input and output never overlap; the single buffer is owned by exactly one phase.
- **Reset** (any state, including mid-FILL or mid-DRAIN):
  - State becomes FILL; `idx`, `buf` and the held `rc`/`last_round` become 0.
  - `out_valid`=0, `out_nibble`=0, `out_last`=0, `in_ready`=1 from the first cycle after reset.
  - A partial round is discarded.

## Timing
- Accept throughput is 1 nibble/cycle in each phase; 16 cycles minimum per phase.
- The last input accept at edge N gives `out_valid`=1 with output index 0 valid after edge N; that is 1-cycle latency.
- The last output accept at edge M gives `in_ready`=1 after edge M.
- Minimum round period is 32 cycles with no stalls.
- `in_ready` depends only on state. It never combinationally depends on `in_valid` or `out_ready`.
- `out_valid`, `out_nibble` and `out_last` are driven from registers only.

## Structure
- `craft_pkg` holds:
  - the SBOX and PERM constant arrays;
  - the `NIBBLES` constant;
  - the state enum {FILL, DRAIN};
  - the constant-insertion indices 4 and 5.
  `craft_mix_columns` and the future encrypt FSM share it.
- One sub-module, `craft_sbox`: combinational 4→4 lookup from `craft_pkg`. It is reused later by the encrypt datapath.

## Test plan
- **S-box path:** all-zero inputs, `key_nibble`=0, `rc`=8'h11, `last_round`=0. The output stream (index 0 first) must read 64'hCCCCCCCCCAACCCCC, with `out_last` only on the 16th nibble.
- **Final-round path:** the same stimulus with `last_round`=1. The output must read 64'h0000110000000000.
- **Permutation order:** `in_nibble`=idx, key 0, `rc` 0. With `last_round`=0 the output must be 64'h60241985FBE7AD3C. With `last_round`=1 it must be 64'h0123456789ABCDEF.
- **Backpressure and sampling:**
  - Drop `out_ready` for 3 cycles at output index 7 and gap `in_valid` randomly during FILL.
  - The output must be identical to the unstalled case, with `out_nibble` stable during stalls and `in_ready`=0 throughout DRAIN.
  - Change `rc` mid-FILL after index 0; the output must be unaffected.
- **Mid-operation reset:**
  - Pulse `rst` after 9 inputs, and again after 5 outputs.
  - Next cycle the block must show `in_ready`=1, `out_valid`=0, `out_nibble`=0.
  - A following full round must match the first scenario's output exactly.
